// File: rtl/reg_file_pkg.sv
// ============================================================================
// reg_file_pkg : shared register-file / datapath constants and types
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_file_pkg;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int IDX_W = 5;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t ZERO_REG = '0;

  function automatic logic is_zero_reg(input idx_t idx);
    return idx == ZERO_REG;
  endfunction

endpackage : reg_file_pkg

`default_nettype wire

// File: rtl/reg_read_port.sv
// ============================================================================
// reg_read_port : one registered read port with write-first bypass and r0 force
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int PORT_W = reg_file_pkg::WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rd_en,
  input  idx_t              i_addr,
  input  logic [PORT_W-1:0] i_rf_data,
  input  logic              i_wr_en,
  input  idx_t              i_wr_addr,
  input  logic [PORT_W-1:0] i_wr_data,
  output logic [PORT_W-1:0] o_data
);

  logic [PORT_W-1:0] w_next;
  logic [PORT_W-1:0] r_data;

  // r0 wins over bypass so a write aimed at r0 can never leak out
  always_comb begin
    w_next = i_rf_data;
    if (is_zero_reg(i_addr)) begin
      w_next = '0;
    end else if (i_wr_en && (i_wr_addr == i_addr)) begin
      w_next = i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_rd_en) begin
      r_data <= w_next;
    end
  end

  assign o_data = r_data;

endmodule : reg_read_port

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// reg_file : 31 x 32-bit register file, r0 hardwired to zero, two 1-cycle
//            registered read ports and one write port
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file #(
  parameter int DEPTH = reg_file_pkg::DEPTH,
  parameter int WIDTH = reg_file_pkg::WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rd_en,
  input  logic [reg_file_pkg::IDX_W-1:0] ra_addr,
  input  logic [reg_file_pkg::IDX_W-1:0] rb_addr,
  output logic [WIDTH-1:0]              a,
  output logic [WIDTH-1:0]              b,
  output logic                          rd_valid,
  input  logic                          wr_en,
  input  logic [reg_file_pkg::IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]              wr_data
);

  import reg_file_pkg::*;

  logic [WIDTH-1:0] r_regs [1:DEPTH-1];
  logic             r_rd_valid;
  logic [WIDTH-1:0] w_rf_a;
  logic [WIDTH-1:0] w_rf_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wr_en && !is_zero_reg(wr_addr)) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Index 0 has no storage; the mux simply never matches it
  always_comb begin
    w_rf_a = '0;
    w_rf_b = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (ra_addr == IDX_W'(i)) w_rf_a = r_regs[i];
      if (rb_addr == IDX_W'(i)) w_rf_b = r_regs[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
    end
  end

  reg_read_port #(.PORT_W(WIDTH)) u_port_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rd_en   (rd_en),
    .i_addr    (ra_addr),
    .i_rf_data (w_rf_a),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .o_data    (a)
  );

  reg_read_port #(.PORT_W(WIDTH)) u_port_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rd_en   (rd_en),
    .i_addr    (rb_addr),
    .i_rf_data (w_rf_b),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .o_data    (b)
  );

  assign rd_valid = r_rd_valid;

endmodule : reg_file

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// tb_reg_file : directed + randomized self-checking bench for reg_file
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en;
  logic [4:0]  ra_addr;
  logic [4:0]  rb_addr;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_valid;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_mem [32];
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        m_v;

  reg_file u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_en),
    .ra_addr  (ra_addr),
    .rb_addr  (rb_addr),
    .a        (a),
    .b        (b),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'h0;
    if (wr_en && (wr_addr == addr)) return wr_data;
    return m_mem[addr];
  endfunction

  // Advance the reference model with the current inputs, then one clock
  task automatic tick();
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
      m_a = 32'h0;
      m_b = 32'h0;
      m_v = 1'b0;
    end else begin
      if (rd_en) begin
        m_a = model_read(ra_addr);
        m_b = model_read(rb_addr);
      end
      m_v = rd_en;
      if (wr_en && (wr_addr != 5'd0)) m_mem[wr_addr] = wr_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic en, input logic [4:0] ra, input logic [4:0] rb);
    rd_en   = en;
    ra_addr = ra;
    rb_addr = rb;
  endtask

  task automatic set_wr(input logic en, input logic [4:0] addr, input logic [31:0] data);
    wr_en   = en;
    wr_addr = addr;
    wr_data = data;
  endtask

  initial begin
    rst_n = 1'b0;
    set_rd(1'b0, 5'd0, 5'd0);
    set_wr(1'b0, 5'd0, 32'h0);
    tick();
    tick();
    check("reset_a", a, 32'h0);
    check("reset_b", b, 32'h0);
    check("reset_valid", {31'h0, rd_valid}, 32'h0);

    // Every index reads zero after reset, one result per cycle
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      set_rd(1'b1, 5'(i), 5'(31 - i));
      tick();
      check("sweep_a", a, 32'h0);
      check("sweep_b", b, 32'h0);
      check("sweep_valid", {31'h0, rd_valid}, 32'h1);
    end
    set_rd(1'b0, 5'd0, 5'd0);
    tick();
    check("valid_drop", {31'h0, rd_valid}, 32'h0);

    set_wr(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(1'b1, 5'd5, 5'd0);
    tick();
    check("r5_a", a, 32'hDEADBEEF);
    check("r5_b", b, 32'h0);
    check("r5_valid", {31'h0, rd_valid}, 32'h1);

    // Idle with garbage addresses must hold a/b
    set_rd(1'b0, 5'd13, 5'd22);
    set_wr(1'b1, 5'd0, 32'h55555555);
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    tick();
    check("hold_a", a, 32'hDEADBEEF);
    check("hold_b", b, 32'h0);
    check("hold_valid", {31'h0, rd_valid}, 32'h0);

    set_wr(1'b1, 5'd7, 32'h12345678);
    set_rd(1'b1, 5'd7, 5'd7);
    tick();
    check("bypass_same_a", a, 32'h12345678);
    check("bypass_same_b", b, 32'h12345678);

    set_wr(1'b1, 5'd9, 32'hCAFEF00D);
    set_rd(1'b1, 5'd9, 5'd5);
    tick();
    check("bypass_portA_only", a, 32'hCAFEF00D);
    check("bypass_portB_stored", b, 32'hDEADBEEF);

    set_wr(1'b1, 5'd9, 32'h0BADC0DE);
    set_rd(1'b1, 5'd7, 5'd9);
    tick();
    check("bypass_portA_stored", a, 32'h12345678);
    check("bypass_portB_only", b, 32'h0BADC0DE);

    set_wr(1'b1, 5'd0, 32'hFFFFFFFF);
    set_rd(1'b0, 5'd0, 5'd0);
    tick();
    set_rd(1'b1, 5'd0, 5'd0);
    tick();
    check("r0_after_write", a, 32'h0);
    check("r0_bypass_a", a, 32'h0);
    check("r0_bypass_b", b, 32'h0);

    // Back-to-back reads of different registers
    set_wr(1'b1, 5'd10, 32'h11111111);
    set_rd(1'b0, 5'd0, 5'd0);
    tick();
    set_wr(1'b1, 5'd11, 32'h22222222);
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(1'b1, 5'd10, 5'd11);
    tick();
    check("b2b_1_a", a, 32'h11111111);
    check("b2b_1_b", b, 32'h22222222);
    set_rd(1'b1, 5'd11, 5'd9);
    tick();
    check("b2b_2_a", a, 32'h22222222);
    check("b2b_2_b", b, 32'h0BADC0DE);
    check("b2b_2_valid", {31'h0, rd_valid}, 32'h1);

    // Reset with a coincident write and read pending
    set_wr(1'b1, 5'd3, 32'hA5A5A5A5);
    set_rd(1'b1, 5'd3, 5'd3);
    tick();
    rst_n = 1'b0;
    set_wr(1'b1, 5'd3, 32'h00000001);
    tick();
    check("rst_valid", {31'h0, rd_valid}, 32'h0);
    check("rst_a", a, 32'h0);
    rst_n = 1'b1;
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(1'b1, 5'd3, 5'd7);
    tick();
    check("post_rst_r3", a, 32'h0);
    check("post_rst_r7", b, 32'h0);
    check("post_rst_valid", {31'h0, rd_valid}, 32'h1);

    // Read issued just before reset must not surface afterward
    set_rd(1'b1, 5'd5, 5'd5);
    tick();
    rst_n = 1'b0;
    set_rd(1'b0, 5'd0, 5'd0);
    tick();
    check("pre_rst_read_valid", {31'h0, rd_valid}, 32'h0);
    rst_n = 1'b1;
    set_wr(1'b1, 5'd2, 32'hABCD0123);
    set_rd(1'b1, 5'd2, 5'd1);
    tick();
    check("first_cycle_a", a, 32'hABCD0123);
    check("first_cycle_b", b, 32'h0);
    check("first_cycle_valid", {31'h0, rd_valid}, 32'h1);

    // Randomized traffic against the reference array
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      set_rd(1'($urandom), 5'($urandom), 5'($urandom));
      set_wr(1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 3) == 0) rb_addr = ra_addr;
      if ($urandom_range(0, 3) == 0) ra_addr = wr_addr;
      tick();
      check("rand_a", a, m_a);
      check("rand_b", b, m_b);
      check("rand_valid", {31'h0, rd_valid}, {31'h0, m_v});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reg_file

`default_nettype wire
